// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: opcodes, mux selects,
// ALU operations and the sequencer state enum.
package riscv_ctrl_pkg;

  // Major opcodes understood by the sequencer
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  // Immediate formats
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // ALU operations
  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b111;

  // ALU A / B operand selects
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // Result mux selects
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImmExt    = 2'b11;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StLui      = 4'd11,
    StTrap     = 4'd12
  } state_e;

  // Immediate format implied by an opcode; unknown opcodes fall back to I
  function automatic logic [2:0] imm_src_for(logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OpStore:  imm = ImmS;
      OpBranch: imm = ImmB;
      OpJal:    imm = ImmJ;
      OpLui:    imm = ImmU;
      default:  imm = ImmI;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mcycle_out_decode.sv
// Moore part of the sequencer: maps the current state to datapath controls.
// The opcode only selects the immediate format while the IR is being decoded
// and during address generation (load uses I, store uses S).
module mcycle_out_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [6:0] opcode,
  output logic       pc_write_uncond,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src
);

  state_e st;
  assign st = state_e'(state);

  // State-to-control lookup, every output defaulted first
  always_comb begin
    pc_write_uncond = 1'b0;
    adr_src         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    imm_src         = ImmI;
    alu_src_a       = SrcAPc;
    alu_src_b       = SrcBRs2;
    alu_op          = AluAdd;
    result_src      = ResAluOut;
    unique case (st)
      StFetch: begin
        mem_read   = 1'b1;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBFour;
        alu_op     = AluAdd;
        result_src = ResAluResult;
      end
      StDecode: begin
        imm_src   = imm_src_for(opcode);
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        imm_src   = imm_src_for(opcode);
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        result_src = ResMemData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluFunct;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluFunct;
      end
      StAluWb: begin
        result_src = ResAluOut;
        reg_write  = 1'b1;
      end
      StBranch: begin
        alu_src_a  = SrcARs1;
        alu_src_b  = SrcBRs2;
        alu_op     = AluSub;
        result_src = ResAluOut;
      end
      StJal: begin
        alu_src_a       = SrcAOldPc;
        alu_src_b       = SrcBFour;
        alu_op          = AluAdd;
        result_src      = ResAluOut;
        pc_write_uncond = 1'b1;
      end
      StLui: begin
        imm_src    = ImmU;
        result_src = ResImmExt;
        reg_write  = 1'b1;
      end
      default: ;  // StTrap and unused codes: everything idle
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 sequencer: state register, next-state logic, sticky
// illegal-opcode flag and the memory-ready / branch Mealy gating.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pc_write_uncond;
  logic   mem_write_raw, reg_write_raw;
  logic   branch_taken;

  // State and sticky illegal flag; reset aborts the instruction immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StLui:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Flag rises together with the TRAP entry so it is visible in TRAP's first cycle
  always_comb begin
    illegal_d = illegal_q | (state_d == StTrap);
  end

  mcycle_out_decode u_out_decode (
    .state           (state_q),
    .opcode          (opcode),
    .pc_write_uncond (pc_write_uncond),
    .adr_src         (adr_src),
    .mem_read        (mem_read),
    .mem_write       (mem_write_raw),
    .reg_write       (reg_write_raw),
    .imm_src         (imm_src),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .alu_op          (alu_op),
    .result_src      (result_src)
  );

  // Mealy enables; rst_n gating keeps them low even while mem_ready is high in reset
  always_comb begin
    branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    pc_write     = rst_n && (pc_write_uncond ||
                             ((state_q == StFetch) && mem_ready) ||
                             ((state_q == StBranch) && branch_taken));
    ir_write     = rst_n && (state_q == StFetch) && mem_ready;
    reg_write    = rst_n && reg_write_raw;
    mem_write    = rst_n && mem_write_raw;
  end

  assign illegal_op = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for the multi-cycle sequencer. Each instruction is expanded
// into its list of phases; the bench walks the list, stretching memory phases
// while mem_ready is low, and checks the controls each phase must show.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] result_src;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // {pc_write, ir_write, reg_write, mem_read, mem_write} a phase must show
  function automatic logic [4:0] exp_en(input int ph, input logic [2:0] f3, input logic z,
                                        input logic rdy);
    logic taken;
    taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    case (ph)
      0:       return {rdy, rdy, 1'b0, 1'b1, 1'b0};
      3:       return 5'b00010;
      4, 8:    return 5'b00100;
      11:      return 5'b00100;
      5:       return 5'b00001;
      9:       return {taken, 4'b0000};
      10:      return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // {adr_src, imm_src, alu_src_a, alu_src_b, alu_op, result_src}
  function automatic logic [12:0] exp_mux(input int ph, input logic [6:0] op);
    case (ph)
      0:       return {1'b0, 3'b000, 2'b00, 2'b10, 3'b000, 2'b10};
      1:       return {1'b0, imm_of(op), 2'b01, 2'b01, 3'b000, 2'b00};
      2:       return {1'b0, imm_of(op), 2'b10, 2'b01, 3'b000, 2'b00};
      3, 5:    return {1'b1, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00};
      4:       return {1'b0, 3'b000, 2'b00, 2'b00, 3'b000, 2'b01};
      6:       return {1'b0, 3'b000, 2'b10, 2'b00, 3'b111, 2'b00};
      7:       return {1'b0, 3'b000, 2'b10, 2'b01, 3'b111, 2'b00};
      9:       return {1'b0, 3'b000, 2'b10, 2'b00, 3'b001, 2'b00};
      10:      return {1'b0, 3'b000, 2'b01, 2'b10, 3'b000, 2'b00};
      11:      return {1'b0, 3'b100, 2'b00, 2'b00, 3'b000, 2'b11};
      default: return 13'd0;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, "_state"}, state_dbg, 0);
    check_val({tag, "_en"}, {pc_write, ir_write, reg_write, mem_read, mem_write}, 5'b00010);
    check_val({tag, "_mux"}, {adr_src, imm_src, alu_src_a, alu_src_b, alu_op, result_src},
              exp_mux(0, 7'd0));
    check_val({tag, "_illegal"}, illegal_op, 0);
  endtask

  // Asserts reset now, checks it for three cycles, releases with FETCH stalled
  task automatic apply_reset(input string tag);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1 check_reset(tag);
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1 check_reset(tag);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  // zmode: -1 random zero, else forced value. abort_ph: phase at which reset is pulled.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int stall_ph,
                           input int stall_n, input int zmode, input int abort_ph);
    int seq[$];
    int pos = 0;
    int cycles = 0;
    int stalled = 0;
    int ph;
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      7'b0100011: begin seq.push_back(2); seq.push_back(5); end
      7'b0110011: begin seq.push_back(6); seq.push_back(8); end
      7'b0010011: begin seq.push_back(7); seq.push_back(8); end
      7'b1100011: seq.push_back(9);
      7'b1101111: begin seq.push_back(10); seq.push_back(8); end
      7'b0110111: seq.push_back(11);
      default:    repeat (11) seq.push_back(12);
    endcase
    opcode = op;
    funct3 = f3;
    while (pos < seq.size()) begin
      @(negedge clk);
      ph        = seq[pos];
      zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (ph == stall_ph && stalled < stall_n) begin
        mem_ready = 1'b0;
        stalled++;
      end
      #1;
      check_val("state", state_dbg, ph);
      check_val("enables", {pc_write, ir_write, reg_write, mem_read, mem_write},
                exp_en(ph, f3, zero, mem_ready));
      check_val("muxes", {adr_src, imm_src, alu_src_a, alu_src_b, alu_op, result_src},
                exp_mux(ph, op));
      check_val("illegal", illegal_op, (ph == 12) ? 1 : 0);
      if (ph == abort_ph) begin
        apply_reset("abort");
        return;
      end
      if (!((ph == 0 || ph == 3 || ph == 5) && !mem_ready)) pos++;
      cycles++;
      if (cycles > 200) begin
        check_val("timeout", cycles, 0);
        return;
      end
    end
  endtask

  logic [6:0] legal_ops [7];

  initial begin
    legal_ops[0] = 7'b0000011;
    legal_ops[1] = 7'b0100011;
    legal_ops[2] = 7'b0110011;
    legal_ops[3] = 7'b0010011;
    legal_ops[4] = 7'b1100011;
    legal_ops[5] = 7'b1101111;
    legal_ops[6] = 7'b0110111;
    rst_n     = 1'b0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #1 apply_reset("por");

    // Directed instructions
    run_instr(7'b0000011, 3'd2, -1, 0, -1, -1);  // lw
    run_instr(7'b0100011, 3'd2, 5, 2, -1, -1);   // sw, two wait cycles in MEMWRITE
    run_instr(7'b1100011, 3'd0, -1, 0, 1, -1);   // beq, zero=1 -> taken
    run_instr(7'b1100011, 3'd1, -1, 0, 1, -1);   // bne, zero=1 -> not taken
    run_instr(7'b1100011, 3'd1, -1, 0, 0, -1);   // bne, zero=0 -> taken
    run_instr(7'b1100011, 3'd4, -1, 0, 1, -1);   // other funct3 -> never taken
    run_instr(7'b1101111, 3'd0, -1, 0, -1, -1);  // jal
    run_instr(7'b0110111, 3'd0, -1, 0, -1, -1);  // lui

    // Random legal instruction stream
    for (int i = 0; i < 300; i++) begin
      run_instr(legal_ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                -1, 0, -1, -1);
    end

    // Reset pulled in MEMWB of a load
    run_instr(7'b0000011, 3'd2, -1, 0, -1, 4);
    run_instr(7'b0110011, 3'd0, -1, 0, -1, -1);

    // Illegal opcode traps and holds until reset
    run_instr(7'b1111111, 3'd0, -1, 0, -1, -1);
    @(negedge clk);
    apply_reset("trap_rst");
    run_instr(7'b0000011, 3'd2, -1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
